// File: rtl/sort_stream_collector_pkg.sv
// Shared definitions for the merge sort stream path: default sample width and
// block size, the collector's fill FSM states, and the signed "greater than"
// helper that is also used by the sort stages.
package sort_pkg;

    localparam int SORT_W_DEF = 8;
    localparam int SORT_N_DEF = 4;

    typedef enum logic {
        FILL_IDLE = 1'b0,
        FILLING   = 1'b1
    } fill_state_e;

    // True when a > b as two's complement numbers; callers sign-extend to 32 bits.
    function automatic logic sort_gt(input logic signed [31:0] a,
                                     input logic signed [31:0] b);
        return a > b;
    endfunction

endpackage

// File: rtl/sort_stream_collector_order_check.sv
// sort_order_check: running descending-order check for one block. Holds the
// previous sample and an accumulated error flag. The flag is cleared when a
// new block starts or on SyncClr. err_o is registered, so it covers the last
// sample of a block in the cycle after that sample is captured.
module sort_order_check
    import sort_pkg::*;
#(
    parameter int W = SORT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] sample_i,
    input  logic                sample_en_i,
    input  logic                block_start_i,
    input  logic                clr_i,
    output logic                err_o
);

    logic signed [W-1:0] prev_q, prev_d;
    logic                err_q, err_d;

    // Next previous-sample and error flag; sample 0 of a block is never compared.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
        prev_d = prev_q;
        err_d  = err_q;
        if (clr_i) begin
            err_d = 1'b0;
        end else if (sample_en_i) begin
            prev_d = sample_i;
            err_d  = block_start_i ? 1'b0
                                   : (err_q | sort_gt(32'(sample_i), 32'(prev_q)));
        end
    end

    // State register for the order checker.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/sort_stream_collector.sv
// sort_stream_collector: regroups the sorter's serial output into blocks of N
// signed samples, flags blocks that are not in descending order and presents
// them on a valid/ready port. A completed block sits in the capture buffer for
// one cycle and is then handed to the output register, or dropped (sticky
// Overflow) when that register is full and not draining.
// Optional feature: define SORT_COLLECT_STATS_EN to add the BlkCount/ErrCount
// saturating counters of accepted and erroneous blocks.
module sort_stream_collector
    import sort_pkg::*;
#(
    parameter int N = SORT_N_DEF,
    parameter int W = SORT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [W-1:0] SortIn,
    input  logic                InValid,
    input  logic                SyncClr,
    output logic [N*W-1:0]      BlkOut,
    output logic                BlkValid,
    input  logic                BlkReady,
    output logic                BlkOrderErr,
    output logic                Overflow
`ifdef SORT_COLLECT_STATS_EN
    ,
    output logic [15:0]         BlkCount,
    output logic [15:0]         ErrCount
`endif
);

    localparam int              IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    fill_state_e         state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic signed [W-1:0] cap_q [N];
    logic signed [W-1:0] cap_d [N];
    logic                done_q, done_d;
    logic [N*W-1:0]      blk_q, blk_d;
    logic                blk_err_q, blk_err_d;
    logic                valid_q, valid_d;
    logic                ovf_q, ovf_d;

    logic                wr_en, block_start, last_slot;
    logic                chk_err;
    logic                drain, load, drop;
    logic [N*W-1:0]      cap_flat;

    // Fill FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FILL_IDLE;
        else     state_q <= state_d;
    end

    // Fill FSM next state: SyncClr realigns, writing slot N-1 ends the block.
    always_comb begin
        state_d = state_q;
        if (SyncClr) begin
            state_d = FILL_IDLE;
        end else begin
            case (state_q)
                FILL_IDLE: if (InValid) state_d = FILLING;
                FILLING:   if (InValid && idx_q == LAST_IDX) state_d = FILL_IDLE;
                default:   state_d = FILL_IDLE;
            endcase
        end
    end

    // Fill FSM outputs: capture strobe, block-start and block-complete events.
    always_comb begin
        wr_en       = InValid & ~SyncClr;
        block_start = 1'b0;
        last_slot   = 1'b0;
        case (state_q)
            FILL_IDLE: block_start = wr_en;
            FILLING:   last_slot   = wr_en && (idx_q == LAST_IDX);
            default:   ;
        endcase
    end

    // Fill index and capture buffer contents.
    always_comb begin
        idx_d = idx_q;
        cap_d = cap_q;
        if (SyncClr) begin
            idx_d = '0;
        end else if (wr_en) begin
            idx_d        = last_slot ? '0 : idx_q + 1'b1;
            cap_d[idx_q] = SortIn;
        end
        done_d = last_slot;
    end

    // Index and completion flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    // Capture buffer storage; every slot is rewritten before a block can complete.
    always_ff @(posedge clk) begin
        // NOTE: the sample array has no reset; stale slots are never observable, so it stays plain storage.
        cap_q <= cap_d;
    end

    sort_order_check #(.W(W)) u_order_check (
        .clk           (clk),
        .rst           (rst),
        .sample_i      (SortIn),
        .sample_en_i   (wr_en),
        .block_start_i (block_start),
        .clr_i         (SyncClr),
        .err_o         (chk_err)
    );

    // Flatten the capture buffer, slot 0 in the least significant sample.
    always_comb begin
        cap_flat = '0;
        for (int k = 0; k < N; k++) cap_flat[k*W +: W] = cap_q[k];
    end

    // Hand-off into the output register, drain on transfer, sticky overflow.
    always_comb begin
        drain     = valid_q & BlkReady;
        load      = done_q & (~valid_q | BlkReady);
        drop      = done_q & ~load;
        blk_d     = blk_q;
        blk_err_d = blk_err_q;
        valid_d   = valid_q;
        if (load) begin
            blk_d     = cap_flat;
            blk_err_d = chk_err;
            valid_d   = 1'b1;
        end else if (drain) begin
            valid_d   = 1'b0;
        end
        ovf_d = ovf_q | drop;
    end

    // Output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q     <= '0;
            blk_err_q <= 1'b0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            blk_q     <= blk_d;
            blk_err_q <= blk_err_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
        end
    end

    assign BlkOut      = blk_q;
    assign BlkValid    = valid_q;
    assign BlkOrderErr = blk_err_q;
    assign Overflow    = ovf_q;

`ifdef SORT_COLLECT_STATS_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating counts of accepted blocks and of accepted blocks with an order error.
    always_comb begin
        blk_cnt_d = blk_cnt_q;
        err_cnt_d = err_cnt_q;
        if (drain) begin
            if (blk_cnt_q != 16'hFFFF) blk_cnt_d = blk_cnt_q + 16'd1;
            if (blk_err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // Statistics counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign BlkCount = blk_cnt_q;
    assign ErrCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_sort_stream_collector.sv
// Self-checking bench for sort_stream_collector (N=4, W=8). Directed scenarios
// check fixed expected blocks; a randomized run compares every cycle against a
// queue-based reference model of the block collector.
module tb_sort_stream_collector;

    localparam int N = 4;
    localparam int W = 8;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] SortIn;
    logic                InValid;
    logic                SyncClr;
    logic [N*W-1:0]      BlkOut;
    logic                BlkValid;
    logic                BlkReady;
    logic                BlkOrderErr;
    logic                Overflow;
`ifdef SORT_COLLECT_STATS_EN
    logic [15:0]         BlkCount;
    logic [15:0]         ErrCount;
`endif

    sort_stream_collector #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .SortIn      (SortIn),
        .InValid     (InValid),
        .SyncClr     (SyncClr),
        .BlkOut      (BlkOut),
        .BlkValid    (BlkValid),
        .BlkReady    (BlkReady),
        .BlkOrderErr (BlkOrderErr),
        .Overflow    (Overflow)
`ifdef SORT_COLLECT_STATS_EN
        ,
        .BlkCount    (BlkCount),
        .ErrCount    (ErrCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: samples of the block being filled, a completed block
    // waiting one cycle for hand-off, and the presented output block.
    logic signed [W-1:0] part[$];
    bit                  m_pend;
    logic [N*W-1:0]      m_pend_blk;
    bit                  m_pend_err;
    bit                  m_valid;
    logic [N*W-1:0]      m_blk;
    bit                  m_err;
    bit                  m_ovf;
    int                  m_blk_cnt;
    int                  m_err_cnt;

    task automatic model_reset();
        part.delete();
        m_pend = 0; m_pend_blk = '0; m_pend_err = 0;
        m_valid = 0; m_blk = '0; m_err = 0; m_ovf = 0;
        m_blk_cnt = 0; m_err_cnt = 0;
    endtask

    task automatic model_edge();
        bit drained;
        drained = m_valid && BlkReady;
        if (drained) begin
            if (m_blk_cnt < 65535) m_blk_cnt++;
            if (m_err && m_err_cnt < 65535) m_err_cnt++;
        end
        if (m_pend) begin
            if (!m_valid || BlkReady) begin
                m_blk = m_pend_blk; m_err = m_pend_err; m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (drained) begin
            m_valid = 0;
        end
        m_pend = 0;
        if (SyncClr) begin
            part.delete();
        end else if (InValid) begin
            part.push_back(SortIn);
            if (part.size() == N) begin
                m_pend = 1;
                m_pend_err = 0;
                for (int k = 0; k < N; k++) begin
                    m_pend_blk[k*W +: W] = part[k];
                    if (k > 0 && part[k] > part[k-1]) m_pend_err = 1;
                end
                part.delete();
            end
        end
    endtask

    // One clock: the model follows the active edge, then outputs settle until the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic send(input logic signed [W-1:0] v);
        InValid = 1'b1;
        SortIn  = v;
        tick();
        InValid = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; InValid = 1'b0; SyncClr = 1'b0; BlkReady = 1'b0; SortIn = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; InValid = 1'b0; SyncClr = 1'b0; BlkReady = 1'b0; SortIn = '0;
        model_reset();
        #1;
        n_cmp++;
        if ({BlkValid, BlkOrderErr, Overflow} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {BlkValid, BlkOrderErr, Overflow});
        end
        n_cmp++;
        if (BlkOut !== 32'h0) begin
            n_bad++; $display("FAIL reset_blkout: got %h want 00000000", BlkOut);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        BlkReady = 1'b1;
        send(8'sd100); send(8'sd50); send(-8'sd3); send(-8'sd128);
        n_cmp++;
        if (BlkValid !== 1'b0) begin
            n_bad++; $display("FAIL basic_latency: BlkValid got %b want 0 at capture edge", BlkValid);
        end
        tick();
        n_cmp++;
        if ({BlkValid, BlkOrderErr} !== 2'b10 || BlkOut !== 32'h80FD3264) begin
            n_bad++; $display("FAIL basic_block: got v=%b e=%b out=%h want v=1 e=0 out=80fd3264",
                              BlkValid, BlkOrderErr, BlkOut);
        end
        tick();
        n_cmp++;
        if (BlkValid !== 1'b0) begin
            n_bad++; $display("FAIL basic_drain: BlkValid got %b want 0", BlkValid);
        end
    endtask

    task automatic test_order();
        apply_reset();
        BlkReady = 1'b1;
        send(8'sd5); send(8'sd7); send(8'sd2); send(8'sd1);
        tick();
        n_cmp++;
        if ({BlkValid, BlkOrderErr} !== 2'b11 || BlkOut !== 32'h01020705) begin
            n_bad++; $display("FAIL order_err: got v=%b e=%b out=%h want v=1 e=1 out=01020705",
                              BlkValid, BlkOrderErr, BlkOut);
        end
        send(8'sd9); send(8'sd9); send(8'sd9); send(8'sd9);
        tick();
        n_cmp++;
        if ({BlkValid, BlkOrderErr} !== 2'b10 || BlkOut !== 32'h09090909) begin
            n_bad++; $display("FAIL order_equal: got v=%b e=%b out=%h want v=1 e=0 out=09090909",
                              BlkValid, BlkOrderErr, BlkOut);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        BlkReady = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(8'(80 - i));
        n_cmp++;
        if (Overflow !== 1'b0) begin
            n_bad++; $display("FAIL ovf_early: Overflow got %b want 0", Overflow);
        end
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (c > 0 && ({BlkValid, Overflow} !== 2'b11 || BlkOut !== 32'h4D4E4F50)) begin
                n_bad++; $display("FAIL ovf_hold%0d: got v=%b ovf=%b out=%h want v=1 ovf=1 out=4d4e4f50",
                                  c, BlkValid, Overflow, BlkOut);
            end
            tick();
        end
        n_cmp++;
        if ({BlkValid, Overflow} !== 2'b11 || BlkOut !== 32'h4D4E4F50) begin
            n_bad++; $display("FAIL ovf_stable: got v=%b ovf=%b out=%h want v=1 ovf=1 out=4d4e4f50",
                              BlkValid, Overflow, BlkOut);
        end
        BlkReady = 1'b1;
        tick();
        BlkReady = 1'b0;
        n_cmp++;
        if ({BlkValid, Overflow} !== 2'b01) begin
            n_bad++; $display("FAIL ovf_drain: got v=%b ovf=%b want v=0 ovf=1", BlkValid, Overflow);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        BlkReady = 1'b0;
        send(8'sd40); send(8'sd30); send(8'sd20); send(8'sd10);
        tick();
        send(8'sd9); send(8'sd8); send(8'sd7); send(8'sd6);
        n_cmp++;
        if (BlkValid !== 1'b1 || BlkOut !== 32'h0A141E28) begin
            n_bad++; $display("FAIL b2b_first: got v=%b out=%h want v=1 out=0a141e28", BlkValid, BlkOut);
        end
        BlkReady = 1'b1;
        tick();
        n_cmp++;
        if ({BlkValid, Overflow} !== 2'b10 || BlkOut !== 32'h06070809) begin
            n_bad++; $display("FAIL b2b_reload: got v=%b ovf=%b out=%h want v=1 ovf=0 out=06070809",
                              BlkValid, Overflow, BlkOut);
        end
        tick();
        BlkReady = 1'b0;
        n_cmp++;
        if (BlkValid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drain: BlkValid got %b want 0", BlkValid);
        end
    endtask

    task automatic test_sync_clr();
        apply_reset();
        BlkReady = 1'b0;
        send(8'sd10); send(8'sd20); send(8'sd30);
        SyncClr = 1'b1;
        send(8'sd99);
        SyncClr = 1'b0;
        send(8'sd4);
        n_cmp++;
        if (BlkValid !== 1'b0) begin
            n_bad++; $display("FAIL sync_no_partial: BlkValid got %b want 0", BlkValid);
        end
        send(8'sd3); send(8'sd2); send(8'sd1);
        tick();
        n_cmp++;
        if ({BlkValid, BlkOrderErr, Overflow} !== 3'b100 || BlkOut !== 32'h01020304) begin
            n_bad++; $display("FAIL sync_block: got v=%b e=%b ovf=%b out=%h want v=1 e=0 ovf=0 out=01020304",
                              BlkValid, BlkOrderErr, Overflow, BlkOut);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        BlkReady = 1'b0;
        send(8'sd1); send(8'sd2); send(8'sd3); send(8'sd4);
        tick();
        send(8'sd50); send(8'sd40);
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if ({BlkValid, BlkOrderErr, Overflow} !== 3'b000 || BlkOut !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid: got v=%b e=%b ovf=%b out=%h want all 0",
                              BlkValid, BlkOrderErr, Overflow, BlkOut);
        end
        @(negedge clk);
        rst = 1'b0;
        send(8'sd10); send(8'sd5); send(8'sd5); send(-8'sd1);
        tick();
        n_cmp++;
        if ({BlkValid, BlkOrderErr} !== 2'b10 || BlkOut !== 32'hFF05050A) begin
            n_bad++; $display("FAIL rst_refill: got v=%b e=%b out=%h want v=1 e=0 out=ff05050a",
                              BlkValid, BlkOrderErr, BlkOut);
        end
        BlkReady = 1'b1;
        tick();
        BlkReady = 1'b0;
        n_cmp++;
        if (BlkValid !== 1'b0) begin
            n_bad++; $display("FAIL rst_accept: BlkValid got %b want 0", BlkValid);
        end
`ifdef SORT_COLLECT_STATS_EN
        n_cmp++;
        if (BlkCount !== 16'd1 || ErrCount !== 16'd0) begin
            n_bad++; $display("FAIL rst_stats: got blk=%0d err=%0d want blk=1 err=0", BlkCount, ErrCount);
        end
`endif
    endtask

    task automatic test_random();
        logic signed [W-1:0] prev;
        apply_reset();
        prev = 8'sd100;
        for (int c = 0; c < 600; c++) begin
            InValid  = ($urandom_range(0, 9) < 8);
            SyncClr  = ($urandom_range(0, 39) == 0);
            BlkReady = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 1) == 0) SortIn = W'($urandom);
            else                           SortIn = prev - W'($urandom_range(0, 3));
            if (InValid) prev = SortIn;
            tick();
            n_cmp++;
            if (BlkValid !== m_valid || Overflow !== m_ovf) begin
                n_bad++; $display("FAIL rand_flags@%0d: got v=%b ovf=%b want v=%b ovf=%b",
                                  c, BlkValid, Overflow, m_valid, m_ovf);
            end
            n_cmp++;
            if (BlkOut !== m_blk || BlkOrderErr !== m_err) begin
                n_bad++; $display("FAIL rand_block@%0d: got out=%h e=%b want out=%h e=%b",
                                  c, BlkOut, BlkOrderErr, m_blk, m_err);
            end
`ifdef SORT_COLLECT_STATS_EN
            n_cmp++;
            if (BlkCount !== 16'(m_blk_cnt) || ErrCount !== 16'(m_err_cnt)) begin
                n_bad++; $display("FAIL rand_stats@%0d: got blk=%0d err=%0d want blk=%0d err=%0d",
                                  c, BlkCount, ErrCount, m_blk_cnt, m_err_cnt);
            end
`endif
        end
        InValid = 1'b0; SyncClr = 1'b0; BlkReady = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_order();
        test_overflow();
        test_back_to_back();
        test_sync_clr();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

endmodule
